// File: rtl/trans_level_sweeper_pkg.sv
// Shared types and constants for the switch-level function cell self-test.
package trans_level_pkg;

  localparam int IDX_W = 4;
  localparam int CNT_W = 5;

  // Truth table of F = AC + ABC' + BD + A'C'D', bit m = F({A,B,C,D} = m)
  localparam logic [15:0] TRANS_LEVEL_TT = 16'hFCB1;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    FINISH
  } state_t;

endpackage

// File: rtl/trans_level_sweeper_settle_timer.sv
// Loadable 4-bit down-counter that times how long each stimulus vector settles.
module settle_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       en,
  output logic [3:0] value,
  output logic       zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (en && (value != '0)) begin
      value <= value - 4'd1;
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/trans_level_sweeper.sv
// Sweeps A..D through all 16 minterms, samples F after a settle delay and
// compares the captured truth table against a golden signature.
module trans_level_sweeper
  import trans_level_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [15:0] EXPECTED      = TRANS_LEVEL_TT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             f_in,
  output logic             a_out,
  output logic             b_out,
  output logic             c_out,
  output logic             d_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      signature,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [IDX_W-1:0] fail_index
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = '1;

  state_t           state, next_state;
  logic [IDX_W-1:0] index;
  logic             tmr_load, tmr_en, tmr_zero;
  logic [3:0]       tmr_value;

  settle_timer u_settle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (SETTLE_LOAD),
    .en       (tmr_en),
    .value    (tmr_value),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    tmr_load   = 1'b0;
    tmr_en     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = SETTLE;
          tmr_load   = 1'b1;
        end
      end
      SETTLE: begin
        if (tmr_zero) next_state = SAMPLE;
        else          tmr_en     = (tmr_value != '0);
      end
      SAMPLE: begin
        if (index == LAST_IDX) begin
          next_state = FINISH;
        end else begin
          next_state = SETTLE;
          tmr_load   = 1'b1;
        end
      end
      FINISH:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // busy drops on entry to FINISH so that done and !busy line up with the
  // single FINISH cycle; pass is only resolved once the last count is in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      signature    <= '0;
      mismatch_cnt <= '0;
      fail_index   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            signature    <= '0;
            mismatch_cnt <= '0;
            fail_index   <= '0;
            pass         <= 1'b0;
            index        <= '0;
            busy         <= 1'b1;
          end
        end
        SAMPLE: begin
          signature[index] <= f_in;
          if (f_in != EXPECTED[index]) begin
            mismatch_cnt <= mismatch_cnt + 5'd1;
            if (mismatch_cnt == '0) fail_index <= index;
          end
          if (index == LAST_IDX) busy  <= 1'b0;
          else                   index <= index + 4'd1;
        end
        FINISH: begin
          done <= 1'b1;
          pass <= (mismatch_cnt == '0);
        end
        default: ;
      endcase
    end
  end

  assign {a_out, b_out, c_out, d_out} = index;

endmodule

// File: tb/tb_trans_level_sweeper.sv
// Self-checking bench: two sweepers (settle 2 and settle 1) driven by a
// truth-table-programmable function block, checked cycle by cycle.
module tb_trans_level_sweeper;

  localparam int NI = 2;
  localparam int S0 = 2;
  localparam int S1 = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NI-1:0] start = '0;
  logic [15:0] tt[NI];
  logic [15:0] gold;

  logic [NI-1:0] f_in_v, a_o, b_o, c_o, d_o, busy_o, done_o, pass_o;
  logic [15:0] sig_o[NI];
  logic [4:0]  mm_o[NI];
  logic [3:0]  fi_o[NI];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign f_in_v[0] = tt[0][{a_o[0], b_o[0], c_o[0], d_o[0]}];
  assign f_in_v[1] = tt[1][{a_o[1], b_o[1], c_o[1], d_o[1]}];

  trans_level_sweeper #(.SETTLE_CYCLES(S0), .EXPECTED(16'hFCB1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .f_in(f_in_v[0]),
    .a_out(a_o[0]), .b_out(b_o[0]), .c_out(c_o[0]), .d_out(d_o[0]),
    .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]),
    .signature(sig_o[0]), .mismatch_cnt(mm_o[0]), .fail_index(fi_o[0]));

  trans_level_sweeper #(.SETTLE_CYCLES(S1), .EXPECTED(16'hFCB1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .f_in(f_in_v[1]),
    .a_out(a_o[1]), .b_out(b_o[1]), .c_out(c_o[1]), .d_out(d_o[1]),
    .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]),
    .signature(sig_o[1]), .mismatch_cnt(mm_o[1]), .fail_index(fi_o[1]));

  function automatic int scyc(int i);
    return (i == 0) ? S0 : S1;
  endfunction

  function automatic int sweep_len(int i);
    return 16 * (scyc(i) + 1) + 1;
  endfunction

  function automatic logic [15:0] formula_tt();
    logic [15:0] r;
    logic [3:0] v;
    logic a, b, c, d;
    for (int m = 0; m < 16; m++) begin
      v = 4'(m);
      {a, b, c, d} = v;
      r[m] = (a & c) | (a & b & ~c) | (b & d) | (~a & ~c & ~d);
    end
    return r;
  endfunction

  task automatic check(input string name, input int i, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s[u%0d] at %0t: got %0h, want %0h", name, i, $time, act, exp);
    end
  endtask

  // Reference model: cycles elapsed since the accepted start edge.
  int          m_t[NI]    = '{0, 0};
  bit          m_act[NI]  = '{0, 0};
  bit          m_done[NI] = '{0, 0};
  bit          m_pass[NI] = '{0, 0};
  int          m_nv[NI]   = '{0, 0};
  int          m_vec[NI]  = '{0, 0};
  logic [15:0] m_tt[NI]   = '{16'h0, 16'h0};

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (!rst_n) begin
        m_act[i] = 0; m_t[i] = 0; m_nv[i] = 0; m_vec[i] = 0;
        m_pass[i] = 0; m_done[i] = 0; m_tt[i] = '0;
      end else begin
        m_done[i] = 0;
        if (m_act[i]) begin
          m_t[i]++;
          m_nv[i]  = (m_t[i] / (scyc(i) + 1) > 16) ? 16 : m_t[i] / (scyc(i) + 1);
          m_vec[i] = (m_nv[i] > 15) ? 15 : m_nv[i];
          if (m_t[i] == sweep_len(i)) begin
            m_act[i]  = 0;
            m_done[i] = 1;
            m_pass[i] = (m_tt[i] == gold);
          end
        end else if (start[i]) begin
          m_act[i] = 1; m_t[i] = 0; m_nv[i] = 0; m_vec[i] = 0;
          m_pass[i] = 0; m_tt[i] = tt[i];
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      logic [15:0] mask, diff;
      int fi_e;
      bit busy_e;
      if (!rst_n) begin
        mask = '0; diff = '0; fi_e = 0; busy_e = 0;
        check("abcd_rst", i, {a_o[i], b_o[i], c_o[i], d_o[i]}, 0);
        check("busy_rst", i, busy_o[i], 0);
        check("done_rst", i, done_o[i], 0);
        check("pass_rst", i, pass_o[i], 0);
        check("sig_rst", i, sig_o[i], 0);
        check("mm_rst", i, mm_o[i], 0);
        check("fi_rst", i, fi_o[i], 0);
      end else begin
        mask = (m_nv[i] >= 16) ? 16'hFFFF : 16'((32'd1 << m_nv[i]) - 1);
        diff = (m_tt[i] ^ gold) & mask;
        fi_e = 0;
        for (int b = 15; b >= 0; b--) if (diff[b]) fi_e = b;
        busy_e = m_act[i] && (m_t[i] <= sweep_len(i) - 2);
        check("abcd", i, {a_o[i], b_o[i], c_o[i], d_o[i]}, m_vec[i]);
        check("busy", i, busy_o[i], busy_e);
        check("done", i, done_o[i], m_done[i]);
        check("pass", i, pass_o[i], m_pass[i]);
        check("signature", i, sig_o[i], m_tt[i] & mask);
        check("mismatch_cnt", i, mm_o[i], $countones(diff));
        check("fail_index", i, fi_o[i], fi_e);
      end
    end
  end

  task automatic do_start(input int i);
    @(negedge clk);
    start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
  endtask

  // Called at the negedge just after the accepted start edge.
  task automatic wait_done(input int i, input int exp_n, input int exp_busy);
    int n, nb;
    n  = 0;
    nb = busy_o[i] ? 1 : 0;
    while (!done_o[i] && n < 300) begin
      @(negedge clk);
      n++;
      if (busy_o[i]) nb++;
    end
    check("done_latency", i, n, exp_n);
    check("busy_cycles", i, nb, exp_busy);
  endtask

  task automatic check_result(input int i, input logic [15:0] s, input int mm,
                              input int fi, input int p);
    check("lit_signature", i, sig_o[i], s);
    check("lit_mismatch", i, mm_o[i], mm);
    check("lit_fail_index", i, fi_o[i], fi);
    check("lit_pass", i, pass_o[i], p);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    gold  = formula_tt();
    tt[0] = gold;
    tt[1] = gold;
    check("formula_tt", 0, gold, 16'hFCB1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Golden function block
    do_start(0);
    wait_done(0, 49, 48);
    check_result(0, 16'hFCB1, 0, 0, 1);

    // F stuck at 0
    tt[0] = 16'h0000;
    do_start(0);
    wait_done(0, 49, 48);
    check_result(0, 16'h0000, 10, 0, 0);

    // Minterm 6 forced high
    tt[0] = gold | 16'h0040;
    do_start(0);
    wait_done(0, 49, 48);
    check_result(0, 16'hFCF1, 1, 6, 0);

    // Second start during vector 5 is ignored
    tt[0] = gold;
    do_start(0);
    repeat (14) @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    wait_done(0, 34, 33);
    check_result(0, 16'hFCB1, 0, 0, 1);

    // Asynchronous reset during vector 9
    tt[0] = 16'h0000;
    do_start(0);
    repeat (27) @(negedge clk);
    check("pre_reset_vec", 0, {a_o[0], b_o[0], c_o[0], d_o[0]}, 9);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_busy", 0, busy_o[0], 0);
    check("async_abcd", 0, {a_o[0], b_o[0], c_o[0], d_o[0]}, 0);
    check("async_sig", 0, sig_o[0], 0);
    check("async_mm", 0, mm_o[0], 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tt[0] = gold;
    do_start(0);
    wait_done(0, 49, 48);
    check_result(0, 16'hFCB1, 0, 0, 1);

    // Settle of 1, then back-to-back start in the cycle after done
    tt[1] = 16'h0000;
    do_start(1);
    wait_done(1, 33, 32);
    check_result(1, 16'h0000, 10, 0, 0);
    tt[1] = gold;
    start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    wait_done(1, 33, 32);
    check_result(1, 16'hFCB1, 0, 0, 1);

    // Randomised sweeps on both instances, with stray starts
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        start[i] = ($urandom % 16 == 0);
        if (!m_act[i] && ($urandom % 4 == 0))
          tt[i] = ($urandom % 3 == 0) ? gold : 16'($urandom);
      end
    end
    start = '0;
    for (int c = 0; c < 200 && (m_act[0] || m_act[1]); c++) @(negedge clk);
    check("drained", 0, m_act[0] || m_act[1], 0);
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/trans_level_sweeper.md
Name: trans_level_sweeper

Overview:
- Sequential stimulus/response stage wrapped around the transistor-level function block F = AC + ABC' + BD + A'C'D'.
- Upstream: drives A,B,C,D through all 16 minterms in ascending order.
- Downstream: samples F after a programmable settle time, builds a 16-bit truth-table signature and compares it against a golden value.
- Used as the built-in self-test for the switch-level function cell.

Parameters:
- SETTLE_CYCLES, 2, clock cycles each vector is held before F is sampled; legal range 1..15.
- EXPECTED, 16'hFCB1, golden truth table; bit m = F for minterm m = {A,B,C,D}, A is MSB.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a sweep.
- f_in  in  1  F output of the function block; synchronous to clk at sample time.
- a_out  out  1  stimulus A.
- b_out  out  1  stimulus B.
- c_out  out  1  stimulus C.
- d_out  out  1  stimulus D.
- busy  out  1  high while a sweep is in progress.
- done  out  1  one-cycle pulse when the sweep completes.
- pass  out  1  signature == EXPECTED; valid from done, held until next start.
- signature  out  16  captured truth table.
- mismatch_cnt  out  5  number of minterms differing from EXPECTED (0..16).
- fail_index  out  4  lowest mismatching minterm; 0 when mismatch_cnt==0.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; a/b/c/d_out=0; busy=0; done=0; pass=0; signature=0; mismatch_cnt=0; fail_index=0; index=0; settle counter=0.
- States: IDLE, SETTLE, SAMPLE, FINISH.
- IDLE, start=1 at edge k:
  - clear signature, mismatch_cnt, fail_index and pass; index=0.
  - drive {a,b,c,d}=4'h0; load settle counter with SETTLE_CYCLES-1; busy=1 from k.
  - go to SETTLE.
- SETTLE: decrement each cycle; at 0 go to SAMPLE. Stimulus is stable throughout.
- SAMPLE (one cycle):
  - signature[index] <= f_in.
  - If f_in != EXPECTED[index]: mismatch_cnt++, and fail_index <= index if this is the first mismatch.
  - If index==15 go to FINISH; otherwise index++, drive the new index on {a,b,c,d}, reload the settle counter, go to SETTLE.
- Cycles per vector: SETTLE_CYCLES+1.
- FINISH (one cycle): busy=0; done=1; pass=(mismatch_cnt==0); go to IDLE. Stimulus holds 4'hF.
- First done pulse occurs 16*(SETTLE_CYCLES+1)+1 cycles after the start edge.
- start while busy: ignored, no restart, no error.
- start in the FINISH cycle: ignored. start in the cycle after done: accepted.
- Index wrap: 15 never wraps to 0 inside a sweep; it terminates.
- Reset mid-sweep: immediate return to reset values; partial signature is discarded.
- mismatch_cnt saturates naturally at 16 (5 bits); no overflow possible.
- All outputs are registered; no combinational path from f_in to any output.

Decomposition:
- Shared package trans_level_pkg holds:
  - state enum (IDLE, SETTLE, SAMPLE, FINISH);
  - constant TRANS_LEVEL_TT = 16'hFCB1;
  - localparam IDX_W=4, CNT_W=5.
- One sub-module: settle_timer. Loadable 4-bit down-counter with load, value and zero outputs, same clk/rst_n.

Test Plan:
- Correct DUT, SETTLE_CYCLES=2: start pulse -> busy for 48 cycles; done at start+49; signature=16'hFCB1; pass=1; mismatch_cnt=0; fail_index=0.
- f_in tied to 0 -> signature=16'h0000; mismatch_cnt=10; fail_index=0; pass=0.
- Model with minterm 6 forced to 1 -> signature=16'hFCF1; mismatch_cnt=1; fail_index=6; pass=0.
- start pulsed again at vector 5 -> ignored; sweep completes normally with a single done pulse; stimulus sequence is monotonic 0..15.
- rst_n low during vector 9 -> all outputs 0 asynchronously; a fresh start then yields 16'hFCB1 and pass=1.
- SETTLE_CYCLES=1 -> each vector held exactly 2 cycles; done at start+33; back-to-back start immediately after done is accepted.
